// File: rtl/pressure_frame_receiver.sv
// UART-style receiver for the pressure sensor line; emits a DATA_WIDTH-bit word with a one-cycle valid strobe.
// Optional even-parity bit after the data bits is enabled by defining PRESSURE_PARITY_EN.
module pressure_frame_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sensorSerial,
  output logic [DATA_WIDTH-1:0] pressureData,
  output logic                  dataValid,
  output logic                  frameError
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

`ifdef PRESSURE_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rxState_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} rxState_t;
`endif

  rxState_t state, nextState;

  logic rxMeta, rxS, rxPrev;
  logic [CNT_W-1:0] baudCnt;
  logic [IDX_W-1:0] bitIdx;
  logic [DATA_WIDTH-1:0] shiftReg;
  logic baudClear, sampleData, stopGood, stopBad, parityOk;

  // Synchronizer and edge-history flops reset high so a released reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= sensorSerial;
      rxS    <= rxMeta;
      rxPrev <= rxS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (rxPrev && !rxS) nextState = START;
      START: if (baudCnt == HALF_LAST) nextState = rxS ? IDLE : DATA;
      DATA:
        if (baudCnt == BIT_LAST && bitIdx == IDX_LAST) begin
`ifdef PRESSURE_PARITY_EN
          nextState = PARITY;
`else
          nextState = STOP;
`endif
        end
`ifdef PRESSURE_PARITY_EN
      PARITY: if (baudCnt == BIT_LAST) nextState = STOP;
`endif
      STOP:  if (baudCnt == BIT_LAST) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

`ifdef PRESSURE_PARITY_EN
  logic sampleParity, parityBit;
`endif

  // Stop decision lands half a bit early so back-to-back start edges are still caught in IDLE.
  always_comb begin
    baudClear  = 1'b0;
    sampleData = 1'b0;
    stopGood   = 1'b0;
    stopBad    = 1'b0;
`ifdef PRESSURE_PARITY_EN
    sampleParity = 1'b0;
`endif
    case (state)
      IDLE:  baudClear = 1'b1;
      START: baudClear = (baudCnt == HALF_LAST);
      DATA: begin
        baudClear  = (baudCnt == BIT_LAST);
        sampleData = (baudCnt == BIT_LAST);
      end
`ifdef PRESSURE_PARITY_EN
      PARITY: begin
        baudClear    = (baudCnt == BIT_LAST);
        sampleParity = (baudCnt == BIT_LAST);
      end
`endif
      STOP: begin
        baudClear = (baudCnt == BIT_LAST);
        stopGood  = (baudCnt == BIT_LAST) && rxS && parityOk;
        stopBad   = (baudCnt == BIT_LAST) && !(rxS && parityOk);
      end
      default: baudClear = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
    end else begin
      baudCnt <= baudClear ? '0 : baudCnt + 1'b1;
      if (state != DATA)  bitIdx <= '0;
      else if (sampleData) bitIdx <= bitIdx + 1'b1;
      if (sampleData) shiftReg <= {rxS, shiftReg[DATA_WIDTH-1:1]};
    end
  end

`ifdef PRESSURE_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               parityBit <= 1'b0;
    else if (sampleParity) parityBit <= rxS;
  end
  assign parityOk = ~(^shiftReg ^ parityBit);
`else
  assign parityOk = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pressureData <= '0;
      dataValid    <= 1'b0;
      frameError   <= 1'b0;
    end else begin
      dataValid  <= stopGood;
      frameError <= stopBad;
      if (stopGood) pressureData <= shiftReg;
    end
  end

endmodule

// File: tb/tb_pressure_frame_receiver.sv
// Directed testbench for pressure_frame_receiver: table of frames plus hand-written reset, glitch, break,
// back-to-back and (with PRESSURE_PARITY_EN) parity sequences.
module tb_pressure_frame_receiver;

  localparam int CLKS_PER_BIT = 16;
  localparam int DATA_WIDTH   = 6;
`ifdef PRESSURE_PARITY_EN
  localparam int FRAME_BITS = DATA_WIDTH + 3;
`else
  localparam int FRAME_BITS = DATA_WIDTH + 2;
`endif

  typedef struct {
    logic [5:0] data;
    logic       stopBit;
    logic       parityBit;
    int         expValid;
    int         expError;
    logic [5:0] expData;
  } frameVec_t;

  logic clk = 1'b0;
  logic rst;
  logic sensorSerial;
  logic [DATA_WIDTH-1:0] pressureData;
  logic dataValid, frameError;

  int checks = 0;
  int errors = 0;
  int validCount = 0, errorCount = 0, cycleCount = 0;
  int widePulses = 0, overlapPulses = 0;
  logic prevValid = 1'b0, prevError = 1'b0;
  logic [5:0] validLog[$];
  int validTime[$];

  frameVec_t vecs[6];

  always #5 clk = ~clk;

  pressure_frame_receiver #(.CLKS_PER_BIT(CLKS_PER_BIT), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .sensorSerial(sensorSerial),
    .pressureData(pressureData),
    .dataValid(dataValid),
    .frameError(frameError)
  );

  // Pulse monitor sampled on the inactive edge.
  always @(negedge clk) begin
    cycleCount++;
    if (dataValid) begin
      validCount++;
      validLog.push_back(pressureData);
      validTime.push_back(cycleCount);
    end
    if (frameError) errorCount++;
    if (dataValid && prevValid) widePulses++;
    if (frameError && prevError) widePulses++;
    if (dataValid && frameError) overlapPulses++;
    prevValid = dataValid;
    prevError = frameError;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic driveBit(input logic b);
    sensorSerial = b;
    repeat (CLKS_PER_BIT) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [5:0] d, input logic stopBit, input logic parityBit);
    driveBit(1'b0);
    for (int i = 0; i < DATA_WIDTH; i++) driveBit(d[i]);
`ifdef PRESSURE_PARITY_EN
    driveBit(parityBit);
`endif
    driveBit(stopBit);
  endtask

  task automatic applyStimulus(input int idx, input frameVec_t v);
    int v0, e0;
    v0 = validCount;
    e0 = errorCount;
    sendFrame(v.data, v.stopBit, v.parityBit);
    driveBit(1'b1);
    driveBit(1'b1);
    checkOutput($sformatf("vec%0d valid", idx), validCount - v0, v.expValid);
    checkOutput($sformatf("vec%0d error", idx), errorCount - e0, v.expError);
    checkOutput($sformatf("vec%0d data", idx), int'(pressureData), int'(v.expData));
  endtask

  initial begin
    int v0, e0, base;

    // Parity bits below are the even-parity values of each payload.
    vecs[0] = '{6'b000000, 1'b1, 1'b0, 1, 0, 6'b000000};
    vecs[1] = '{6'b111111, 1'b1, 1'b0, 1, 0, 6'b111111};
    vecs[2] = '{6'b010101, 1'b1, 1'b1, 1, 0, 6'b010101};
    vecs[3] = '{6'b101100, 1'b1, 1'b1, 1, 0, 6'b101100};
    vecs[4] = '{6'b110100, 1'b0, 1'b1, 0, 1, 6'b101100};
    vecs[5] = '{6'b101100, 1'b1, 1'b1, 1, 0, 6'b101100};

    rst = 1'b1;
    sensorSerial = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset data", int'(pressureData), 0);
    checkOutput("reset valid", int'(dataValid), 0);
    checkOutput("reset error", int'(frameError), 0);
    rst = 1'b0;
    driveBit(1'b1);
    driveBit(1'b1);

    v0 = validCount;
    sendFrame(6'b011011, 1'b1, 1'b0);
    driveBit(1'b1);
    checkOutput("pre-reset frame", int'(pressureData), int'(6'b011011));

    // Assert reset asynchronously in the middle of data bit 1.
    sensorSerial = 1'b0;
    repeat (CLKS_PER_BIT) @(negedge clk);
    sensorSerial = 1'b1;
    repeat (CLKS_PER_BIT + 8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midframe reset data", int'(pressureData), 0);
    checkOutput("midframe reset valid", int'(dataValid), 0);
    checkOutput("midframe reset error", int'(frameError), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    driveBit(1'b1);
    driveBit(1'b1);
    v0 = validCount;
    e0 = errorCount;
    sendFrame(6'b000100, 1'b1, 1'b1);
    driveBit(1'b1);
    checkOutput("post-reset valid", validCount - v0, 1);
    checkOutput("post-reset error", errorCount - e0, 0);
    checkOutput("post-reset data", int'(pressureData), int'(6'b000100));

    for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

    v0 = validCount;
    e0 = errorCount;
    sensorSerial = 1'b0;
    repeat (4) @(negedge clk);
    sensorSerial = 1'b1;
    repeat (3 * CLKS_PER_BIT) @(negedge clk);
    checkOutput("glitch valid", validCount - v0, 0);
    checkOutput("glitch error", errorCount - e0, 0);
    checkOutput("glitch data", int'(pressureData), int'(6'b101100));

    // Break: stop bit low and line held low afterwards.
    v0 = validCount;
    e0 = errorCount;
    sendFrame(6'b110100, 1'b0, 1'b1);
    repeat (3) driveBit(1'b0);
    checkOutput("break error", errorCount - e0, 1);
    checkOutput("break valid", validCount - v0, 0);
    checkOutput("break data", int'(pressureData), int'(6'b101100));
    driveBit(1'b1);
    driveBit(1'b1);
    sendFrame(6'b011010, 1'b1, 1'b1);
    driveBit(1'b1);
    checkOutput("after-break valid", validCount - v0, 1);
    checkOutput("after-break error", errorCount - e0, 1);
    checkOutput("after-break data", int'(pressureData), int'(6'b011010));

    base = validLog.size();
    v0 = validCount;
    sendFrame(6'b000110, 1'b1, 1'b0);
    sendFrame(6'b111100, 1'b1, 1'b0);
    driveBit(1'b1);
    driveBit(1'b1);
    checkOutput("b2b count", validCount - v0, 2);
    if (validLog.size() >= base + 2) begin
      checkOutput("b2b first", int'(validLog[base]), int'(6'b000110));
      checkOutput("b2b second", int'(validLog[base + 1]), int'(6'b111100));
      checkOutput("b2b spacing", validTime[base + 1] - validTime[base], FRAME_BITS * CLKS_PER_BIT);
    end else begin
      checkOutput("b2b log size", validLog.size() - base, 2);
    end

`ifdef PRESSURE_PARITY_EN
    v0 = validCount;
    e0 = errorCount;
    sendFrame(6'b001101, 1'b1, 1'b1);
    driveBit(1'b1);
    checkOutput("parity good valid", validCount - v0, 1);
    checkOutput("parity good data", int'(pressureData), int'(6'b001101));
    v0 = validCount;
    sendFrame(6'b001101, 1'b1, 1'b0);
    driveBit(1'b1);
    checkOutput("parity bad valid", validCount - v0, 0);
    checkOutput("parity bad error", errorCount - e0, 1);
    checkOutput("parity bad data", int'(pressureData), int'(6'b001101));
`endif

    checkOutput("pulse width", widePulses, 0);
    checkOutput("pulse overlap", overlapPulses, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
